// File: rtl/lutram_tcam_ctrl_if.sv
// Update and search handshake plus result bus of the LUTRAM TCAM.
interface lutram_tcam_ctrl_if #(
    parameter int WIDTH = 36,
    parameter int AW    = 9
);
    logic             wValid;
    logic             wReady;
    logic             wOp;
    logic [AW-1:0]    wAddr;
    logic [WIDTH-1:0] wPatt;
    logic [WIDTH-1:0] wMask;
    logic             sValid;
    logic             sReady;
    logic [WIDTH-1:0] sPatt;
    logic             rValid;
    logic             match;
    logic             multi;
    logic [AW-1:0]    mAddr;

    modport master (
        output wValid, wOp, wAddr, wPatt, wMask, sValid, sPatt,
        input  wReady, sReady, rValid, match, multi, mAddr
    );

    modport slave (
        input  wValid, wOp, wAddr, wPatt, wMask, sValid, sPatt,
        output wReady, sReady, rValid, match, multi, mAddr
    );
endinterface

// File: rtl/lutram_tcam_ctrl.sv
// Ternary CAM built from per-entry LUT sub-tables; search result 2 cycles after accept, 1 search/cycle.
// An update sweeps all 2^LUT_AW LUT addresses, holding wReady/sReady low; a write beats a search in the same cycle.
module lutram_tcam_ctrl #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 36,
    parameter int LUT_AW = 6,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    lutram_tcam_ctrl_if.slave bus
);
    localparam int SUBS = (WIDTH + LUT_AW - 1) / LUT_AW;
    localparam int PW   = SUBS * LUT_AW;
    localparam int TBL  = 1 << LUT_AW;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [LUT_AW-1:0] cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [PW-1:0]     patt_q, patt_d;
    logic [PW-1:0]     mask_q, mask_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TBL-1:0]    tbl_q [DEPTH][SUBS];
    logic [SUBS-1:0]   upd_bit;
    logic              tbl_we;
    logic [PW-1:0]     key_pad;
    logic [DEPTH-1:0]  mv_q, mv_d;
    logic              vld1_q, vld1_d;
    logic              rvalid_q, rvalid_d;
    logic              match_q, match_d;
    logic              multi_q, multi_d;
    logic [AW-1:0]     maddr_q, maddr_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        patt_d      = patt_q;
        mask_d      = mask_q;
        valid_d     = valid_q;
        tbl_we      = 1'b0;
        bus.wReady  = 1'b0;
        bus.sReady  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.wReady = 1'b1;
                bus.sReady = !bus.wValid;
                if (bus.wValid) begin
                    op_d    = bus.wOp;
                    addr_d  = bus.wAddr;
                    patt_d  = PW'(bus.wPatt);
                    // padding bits come out as don't-care
                    mask_d  = ~PW'(~bus.wMask);
                    valid_d[bus.wAddr] = 1'b0;
                    cnt_d   = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                tbl_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LUT_AW'(TBL - 1)) begin
                    valid_d[addr_q] = !op_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        upd_bit = '0;
        for (int s = 0; s < SUBS; s++) begin
            upd_bit[s] = !op_q &&
                (((cnt_q ^ patt_q[s*LUT_AW +: LUT_AW]) & ~mask_q[s*LUT_AW +: LUT_AW]) == '0);
        end
    end

    // Table contents are never reset; valid_q gates them.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            for (int s = 0; s < SUBS; s++) begin
                tbl_q[addr_q][s][cnt_q] <= upd_bit[s];
            end
        end
    end

    always_comb begin
        key_pad = PW'(bus.sPatt);
        vld1_d  = bus.sValid && bus.sReady;
        mv_d    = mv_q;
        if (vld1_d) begin
            for (int e = 0; e < DEPTH; e++) begin
                mv_d[e] = valid_q[e];
                for (int s = 0; s < SUBS; s++) begin
                    mv_d[e] = mv_d[e] & tbl_q[e][s][key_pad[s*LUT_AW +: LUT_AW]];
                end
            end
        end
    end

    // Descending scan: the last hit is the lowest index, any earlier hit means multi.
    always_comb begin
        rvalid_d = vld1_q;
        match_d  = match_q;
        multi_d  = multi_q;
        maddr_d  = maddr_q;
        if (vld1_q) begin
            match_d = 1'b0;
            multi_d = 1'b0;
            maddr_d = '0;
            for (int e = DEPTH - 1; e >= 0; e--) begin
                if (mv_q[e]) begin
                    multi_d = match_d;
                    match_d = 1'b1;
                    maddr_d = AW'(e);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            patt_q   <= '0;
            mask_q   <= '0;
            valid_q  <= '0;
            mv_q     <= '0;
            vld1_q   <= 1'b0;
            rvalid_q <= 1'b0;
            match_q  <= 1'b0;
            multi_q  <= 1'b0;
            maddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            patt_q   <= patt_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            mv_q     <= mv_d;
            vld1_q   <= vld1_d;
            rvalid_q <= rvalid_d;
            match_q  <= match_d;
            multi_q  <= multi_d;
            maddr_q  <= maddr_d;
        end
    end

    assign bus.rValid = rvalid_q;
    assign bus.match  = match_q;
    assign bus.multi  = multi_q;
    assign bus.mAddr  = maddr_q;
endmodule

// File: tb/tb_lutram_tcam_ctrl.sv
// Scoreboard bench: two TCAMs (12-bit and padded 13-bit keys) against a plain ternary-compare model.
module tb_lutram_tcam_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lutram_tcam_ctrl_if #(.WIDTH(12), .AW(AW)) ifa ();
    lutram_tcam_ctrl_if #(.WIDTH(13), .AW(AW)) ifb ();

    lutram_tcam_ctrl #(.DEPTH(DEPTH), .WIDTH(12), .LUT_AW(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    lutram_tcam_ctrl #(.DEPTH(DEPTH), .WIDTH(13), .LUT_AW(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        logic          m;
        logic          mu;
        logic [AW-1:0] a;
        int            c;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] mp[2][DEPTH];
    logic [15:0] mm[2][DEPTH];
    bit          mv[2][DEPTH];
    int          b_last = -10;
    int          b_run = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] wmask(int sel);
        return (sel == 0) ? 16'h0FFF : 16'h1FFF;
    endfunction

    // Reference: an entry hits when it is valid and every unmasked key bit equals its pattern bit.
    function automatic exp_t model(int sel, logic [15:0] key);
        exp_t r;
        int   n = 0;
        r.m = 1'b0; r.mu = 1'b0; r.a = '0; r.c = 0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (mv[sel][e] && (((key ^ mp[sel][e]) & ~mm[sel][e] & wmask(sel)) == 16'h0)) begin
                n++;
                r.a = AW'(e);
            end
        end
        r.m  = (n >= 1);
        r.mu = (n >= 2);
        return r;
    endfunction

    task automatic set_in(int sel, bit wv, bit op, int addr, logic [15:0] p, logic [15:0] m,
                          bit sv, logic [15:0] k);
        if (sel == 0) begin
            ifa.wValid = wv; ifa.wOp = op; ifa.wAddr = AW'(addr);
            ifa.wPatt = p[11:0]; ifa.wMask = m[11:0]; ifa.sValid = sv; ifa.sPatt = k[11:0];
        end else begin
            ifb.wValid = wv; ifb.wOp = op; ifb.wAddr = AW'(addr);
            ifb.wPatt = p[12:0]; ifb.wMask = m[12:0]; ifb.sValid = sv; ifb.sPatt = k[12:0];
        end
    endtask

    function automatic bit s_rdy(int sel);
        return (sel == 0) ? ifa.sReady : ifb.sReady;
    endfunction

    function automatic bit w_rdy(int sel);
        return (sel == 0) ? ifa.wReady : ifb.wReady;
    endfunction

    task automatic idle();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Drives one search cycle; sValid stays high so consecutive calls are back-to-back.
    task automatic do_search(int sel, logic [15:0] key);
        exp_t x;
        int   guard = 0;
        @(negedge clk);
        set_in(sel, 0, 0, 0, 0, 0, 1, key);
        #1;
        while (!s_rdy(sel)) begin
            guard++;
            if (guard > 200) begin
                check("search_ready_timeout", guard, 0);
                return;
            end
            @(negedge clk);
            #1;
        end
        x   = model(sel, key & wmask(sel));
        x.c = cyc + 2;
        if (sel == 0) qa.push_back(x);
        else          qb.push_back(x);
    endtask

    task automatic do_write(int sel, bit op, int addr, logic [15:0] p, logic [15:0] m,
                            bit with_search, bit wait_done);
        int guard = 0;
        @(negedge clk);
        set_in(sel, 1, op, addr, p, m, with_search, 16'h0ABC);
        #1;
        while (!w_rdy(sel)) begin
            guard++;
            if (guard > 200) begin
                check("write_ready_timeout", guard, 0);
                return;
            end
            @(negedge clk);
            #1;
        end
        if (with_search) check("prio_sready", s_rdy(sel), 0);
        mp[sel][addr] = p & wmask(sel);
        mm[sel][addr] = m & wmask(sel);
        mv[sel][addr] = !op;
        idle();
        if (wait_done) begin
            guard = 0;
            while (!w_rdy(sel) && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            check("update_busy_cycles", guard, 64);
        end
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        check("drain_queue_a", qa.size(), 0);
        check("drain_queue_b", qb.size(), 0);
    endtask

    task automatic mon(int sel, logic m, logic mu, logic [AW-1:0] a);
        exp_t x;
        if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rvalid: dut %0d got rValid=1, expected no result (cycle %0d)", sel, cyc);
            return;
        end
        if (sel == 0) x = qa.pop_front();
        else          x = qb.pop_front();
        check("latency", cyc, x.c);
        check("match", m, x.m);
        check("multi", mu, x.mu);
        check("maddr", a, x.a);
    endtask

    always @(negedge clk) begin
        if (ifa.rValid) mon(0, ifa.match, ifa.multi, ifa.mAddr);
        if (ifb.rValid) begin
            mon(1, ifb.match, ifb.multi, ifb.mAddr);
            b_run  = (b_last == cyc - 1) ? b_run + 1 : 1;
            b_last = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] k;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s < 2; s++)
            for (int e = 0; e < DEPTH; e++) begin
                mv[s][e] = 0; mp[s][e] = 0; mm[s][e] = 0;
            end
        repeat (3) @(negedge clk);
        check("rst_rvalid", ifa.rValid, 0);
        check("rst_match", ifa.match, 0);
        check("rst_maddr", ifa.mAddr, 0);
        check("rst_wready", ifa.wReady, 1);
        rst_n = 1'b1;

        do_search(0, 16'h0ABC);
        idle();
        drain();

        do_write(0, 0, 3, 16'h0ABC, 16'h0000, 0, 1);
        do_search(0, 16'h0ABC);
        do_search(0, 16'h0ABD);
        idle();
        do_write(0, 0, 1, 16'h0AB0, 16'h000F, 0, 1);
        do_search(0, 16'h0AB7);
        do_search(0, 16'h0ABC);
        idle();
        do_write(0, 1, 1, 16'h0000, 16'h0000, 0, 1);
        do_search(0, 16'h0AB7);
        do_search(0, 16'h0ABC);
        idle();
        do_write(0, 1, 6, 16'h0000, 16'h0000, 0, 1);
        do_write(0, 0, 7, 16'h0000, 16'h0FFF, 0, 1);
        do_search(0, 16'h0123);
        do_search(0, 16'h0ABC);
        idle();
        drain();

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                do_write(0, ($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1),
                         16'($urandom) & 16'h0FFF, 16'($urandom & $urandom & $urandom) & 16'h0FFF, 0, 1);
            end else begin
                for (int j = 0; j < $urandom_range(1, 3); j++) begin
                    if ($urandom_range(0, 1) == 1)
                        k = mp[0][$urandom_range(0, DEPTH - 1)] ^ 16'($urandom_range(0, 3));
                    else
                        k = 16'($urandom) & 16'h0FFF;
                    do_search(0, k);
                end
                idle();
            end
        end
        drain();

        do_write(0, 0, 3, 16'h0ABC, 16'h0000, 0, 1);
        do_search(0, 16'h0ABC);
        idle();
        drain();
        do_write(0, 0, 5, 16'h0123, 16'h0000, 1, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", ifa.rValid, 0);
        check("arst_match", ifa.match, 0);
        check("arst_multi", ifa.multi, 0);
        check("arst_maddr", ifa.mAddr, 0);
        check("arst_wready", ifa.wReady, 1);
        for (int s = 0; s < 2; s++)
            for (int e = 0; e < DEPTH; e++) mv[s][e] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_search(0, 16'h0ABC);
        do_search(0, 16'h0123);
        do_search(0, 16'h0000);
        idle();
        drain();

        do_write(1, 0, 0, 16'h1FFF, 16'h0000, 0, 1);
        do_write(1, 0, 2, 16'h0F00, 16'h00FF, 0, 1);
        do_search(1, 16'h1FFF);
        do_search(1, 16'h0FFF);
        idle();
        drain();
        do_search(1, 16'h1FFF);
        do_search(1, 16'h0FFF);
        do_search(1, 16'h0F12);
        do_search(1, 16'h1F12);
        idle();
        drain();
        check("burst_consecutive_rvalid", b_run, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
